// File: rtl/run_context_update_pkg.sv
// Shared constants, field widths and FSM encoding for the run-interruption
// context read-modify-write path.
package run_context_update_pkg;
  localparam int RESET_N = 64;
  localparam int KMAX    = 13;
  localparam int A_W     = 13;
  localparam int N_W     = 7;
  localparam int ERR_W   = 9;
  localparam int K_W     = 4;

  typedef enum logic [1:0] {IDLE, CALC, MAP, WB} state_t;
endpackage

// File: rtl/run_map_calc.sv
// Combinational map bit, EMErrval and updated run context from the latched
// sample and the final k.
module run_map_calc
  import run_context_update_pkg::*;
#(
  parameter int RESET_N = run_context_update_pkg::RESET_N
) (
  input  logic                    ritype,
  input  logic signed [ERR_W-1:0] errval,
  input  logic [A_W-1:0]          a_in,
  input  logic [N_W-1:0]          nn_in,
  input  logic [N_W-1:0]          n_in,
  input  logic [K_W-1:0]          k,
  output logic                    map,
  output logic [ERR_W-1:0]        em_errval,
  output logic [A_W-1:0]          a_out,
  output logic [N_W-1:0]          nn_out,
  output logic [N_W-1:0]          n_out
);
  localparam int EW = ERR_W + 1;

  logic             neg, pos, nn_lt;
  logic [ERR_W-1:0] mag;
  logic [EW-1:0]    em_full;
  logic [EW:0]      a_inc;
  logic [A_W-1:0]   a_acc;
  logic [N_W-1:0]   nn_acc, n_half;

  always_comb begin
    neg     = errval[ERR_W-1];
    pos     = !neg && (errval != '0);
    nn_lt   = {nn_in, 1'b0} < {1'b0, n_in};
    map     = (k == '0 && pos && nn_lt) || (neg && !nn_lt) || (neg && k != '0);
    // -256 negates to 9'h100, which is the correct unsigned magnitude
    mag     = neg ? ERR_W'(-errval) : errval;
    em_full = {mag, 1'b0} - EW'(ritype) - EW'(map);
    em_errval = em_full[ERR_W-1:0];
    a_inc   = ({1'b0, em_full} + (EW+1)'(1) - (EW+1)'(ritype)) >> 1;
    a_acc   = a_in + A_W'(a_inc);
    nn_acc  = nn_in + N_W'(neg);
    n_half  = n_in;
    if (n_in == N_W'(RESET_N)) begin
      a_acc  = a_acc >> 1;
      nn_acc = nn_acc >> 1;
      n_half = n_in >> 1;
    end
    a_out  = a_acc;
    nn_out = nn_acc;
    n_out  = n_half + N_W'(1);
  end
endmodule

// File: rtl/run_context_update.sv
// Run-interruption context consumer: k search, error mapping and one-cycle
// write-back of the updated A/Nn/N to the context store.
module run_context_update
  import run_context_update_pkg::*;
#(
  parameter int RESET_N = run_context_update_pkg::RESET_N,
  parameter int KMAX    = run_context_update_pkg::KMAX
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_in,
  input  logic                    RItype,
  input  logic signed [ERR_W-1:0] Errval,
  input  logic [A_W-1:0]          A_1,
  input  logic [A_W-1:0]          A_0,
  input  logic [N_W-1:0]          Nn_1,
  input  logic [N_W-1:0]          Nn_0,
  input  logic [N_W-1:0]          N_1,
  input  logic [N_W-1:0]          N_0,
  output logic                    busy,
  output logic                    code_valid,
  output logic [K_W-1:0]          k,
  output logic                    map,
  output logic [ERR_W-1:0]        EMErrval,
  output logic                    en_out,
  output logic                    RItype_out,
  output logic [A_W-1:0]          A,
  output logic [N_W-1:0]          Nn,
  output logic [N_W-1:0]          N
);
  state_t                  state_q, state_d;
  logic                    ritype_q, ritype_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic [A_W-1:0]          a_q, a_d;
  logic [N_W-1:0]          nn_q, nn_d, n_q, n_d;
  logic [K_W-1:0]          kc_q, kc_d;

  logic                    code_valid_q, code_valid_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    map_q, map_d;
  logic [ERR_W-1:0]        em_q, em_d;
  logic                    en_out_q, en_out_d;
  logic                    rit_out_q, rit_out_d;
  logic [A_W-1:0]          a_out_q, a_out_d;
  logic [N_W-1:0]          nn_out_q, nn_out_d, n_out_q, n_out_d;

  logic [A_W:0]            temp;
  logic [20:0]             n_shift;
  logic                    k_done;
  logic                    c_map;
  logic [ERR_W-1:0]        c_em;
  logic [A_W-1:0]          c_a;
  logic [N_W-1:0]          c_nn, c_n;

  run_map_calc #(.RESET_N(RESET_N)) u_calc (
    .ritype    (ritype_q),
    .errval    (err_q),
    .a_in      (a_q),
    .nn_in     (nn_q),
    .n_in      (n_q),
    .k         (kc_q),
    .map       (c_map),
    .em_errval (c_em),
    .a_out     (c_a),
    .nn_out    (c_nn),
    .n_out     (c_n)
  );

  // Full-width compare so N<<k never truncates before reaching TEMP
  always_comb begin
    temp    = {1'b0, a_q} + (ritype_q ? (A_W+1)'(n_q >> 1) : '0);
    n_shift = 21'(n_q) << kc_q;
    k_done  = (n_shift >= 21'(temp)) || (kc_q == K_W'(KMAX));
  end

  always_comb begin
    state_d      = state_q;
    ritype_d     = ritype_q;
    err_d        = err_q;
    a_d          = a_q;
    nn_d         = nn_q;
    n_d          = n_q;
    kc_d         = kc_q;
    code_valid_d = 1'b0;
    k_d          = k_q;
    map_d        = map_q;
    em_d         = em_q;
    en_out_d     = 1'b0;
    rit_out_d    = rit_out_q;
    a_out_d      = a_out_q;
    nn_out_d     = nn_out_q;
    n_out_d      = n_out_q;
    case (state_q)
      IDLE: if (en_in) begin
        state_d  = CALC;
        ritype_d = RItype;
        err_d    = Errval;
        a_d      = RItype ? A_1  : A_0;
        nn_d     = RItype ? Nn_1 : Nn_0;
        n_d      = RItype ? N_1  : N_0;
        kc_d     = '0;
      end
      CALC: if (k_done) begin
        state_d      = MAP;
        code_valid_d = 1'b1;
        k_d          = kc_q;
        map_d        = c_map;
        em_d         = c_em;
      end else begin
        kc_d = kc_q + K_W'(1);
      end
      MAP: begin
        state_d   = WB;
        en_out_d  = 1'b1;
        rit_out_d = ritype_q;
        a_out_d   = c_a;
        nn_out_d  = c_nn;
        n_out_d   = c_n;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ritype_q     <= 1'b0;
      err_q        <= '0;
      a_q          <= '0;
      nn_q         <= '0;
      n_q          <= '0;
      kc_q         <= '0;
      code_valid_q <= 1'b0;
      k_q          <= '0;
      map_q        <= 1'b0;
      em_q         <= '0;
      en_out_q     <= 1'b0;
      rit_out_q    <= 1'b0;
      a_out_q      <= '0;
      nn_out_q     <= '0;
      n_out_q      <= '0;
    end else begin
      state_q      <= state_d;
      ritype_q     <= ritype_d;
      err_q        <= err_d;
      a_q          <= a_d;
      nn_q         <= nn_d;
      n_q          <= n_d;
      kc_q         <= kc_d;
      code_valid_q <= code_valid_d;
      k_q          <= k_d;
      map_q        <= map_d;
      em_q         <= em_d;
      en_out_q     <= en_out_d;
      rit_out_q    <= rit_out_d;
      a_out_q      <= a_out_d;
      nn_out_q     <= nn_out_d;
      n_out_q      <= n_out_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign code_valid = code_valid_q;
  assign k          = k_q;
  assign map        = map_q;
  assign EMErrval   = em_q;
  assign en_out     = en_out_q;
  assign RItype_out = rit_out_q;
  assign A          = a_out_q;
  assign Nn         = nn_out_q;
  assign N          = n_out_q;
endmodule

// File: tb/tb_run_context_update.sv
// Directed bench for run_context_update with a two-entry context store model.
module tb_run_context_update;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en_in = 1'b0;
  logic              rit = 1'b0;
  logic signed [8:0] err = '0;
  logic [12:0]       st_a  [2];
  logic [6:0]        st_nn [2];
  logic [6:0]        st_n  [2];

  logic        busy, code_valid, map, en_out, RItype_out;
  logic [3:0]  k;
  logic [8:0]  EMErrval;
  logic [12:0] A;
  logic [6:0]  Nn, N;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_e0 = 0;
  int cur_e0 = 0;

  run_context_update dut (
    .clk(clk), .reset(rst_n), .en_in(en_in), .RItype(rit), .Errval(err),
    .A_1(st_a[1]), .A_0(st_a[0]), .Nn_1(st_nn[1]), .Nn_0(st_nn[0]),
    .N_1(st_n[1]), .N_0(st_n[0]),
    .busy(busy), .code_valid(code_valid), .k(k), .map(map), .EMErrval(EMErrval),
    .en_out(en_out), .RItype_out(RItype_out), .A(A), .Nn(Nn), .N(N)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic set_ctx(input logic s, input logic [12:0] a, input logic [6:0] nn, input logic [6:0] n);
    st_a[s] = a; st_nn[s] = nn; st_n[s] = n;
  endtask

  // Issues one request and follows it to IDLE; g1/g2 are cycles (relative
  // to the accept edge) during which en_in is pulsed again.
  task automatic do_req(input string nm, input logic r, input logic signed [8:0] e,
                        input logic [3:0] xk, input logic xmap, input logic [8:0] xem,
                        input logic [12:0] xa, input logic [6:0] xnn, input logic [6:0] xn,
                        input int g1, input int g2);
    int c = 0, cv_at = -1, cv_cnt = 0, ew_at = -1, ew_cnt = 0;
    logic [12:0] wa = '0;
    logic [6:0]  wnn = '0, wn = '0;
    logic        wr = 1'b0;
    rit = r; err = e; en_in = 1'b1;
    @(posedge clk); #1;
    en_in = 1'b0;
    prev_e0 = cur_e0; cur_e0 = cyc;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s.busy got %0b want 1", nm, busy); end
    while (c < 40) begin
      @(posedge clk); #1; c++;
      en_in = (c == g1) || (c == g2);
      if (code_valid === 1'b1) begin cv_cnt++; cv_at = c; end
      if (en_out === 1'b1) begin
        ew_cnt++; ew_at = c; wa = A; wnn = Nn; wn = N; wr = RItype_out;
        st_a[RItype_out] = A; st_nn[RItype_out] = Nn; st_n[RItype_out] = N;
      end
      if (busy === 1'b0 && ew_cnt > 0) break;
    end
    en_in = 1'b0;
    checks++; if (c != int'(xk) + 3) begin errors++; $display("FAIL %s.idle_at got %0d want %0d", nm, c, int'(xk) + 3); end
    checks++; if (cv_at != int'(xk) + 1) begin errors++; $display("FAIL %s.code_valid_at got %0d want %0d", nm, cv_at, int'(xk) + 1); end
    checks++; if (cv_cnt != 1) begin errors++; $display("FAIL %s.code_valid_len got %0d want 1", nm, cv_cnt); end
    checks++; if (ew_at != int'(xk) + 2) begin errors++; $display("FAIL %s.en_out_at got %0d want %0d", nm, ew_at, int'(xk) + 2); end
    checks++; if (ew_cnt != 1) begin errors++; $display("FAIL %s.en_out_len got %0d want 1", nm, ew_cnt); end
    checks++; if (k !== xk) begin errors++; $display("FAIL %s.k got %0d want %0d", nm, k, xk); end
    checks++; if (map !== xmap) begin errors++; $display("FAIL %s.map got %0b want %0b", nm, map, xmap); end
    checks++; if (EMErrval !== xem) begin errors++; $display("FAIL %s.EMErrval got %0d want %0d", nm, EMErrval, xem); end
    checks++; if (wr !== r) begin errors++; $display("FAIL %s.RItype_out got %0b want %0b", nm, wr, r); end
    checks++; if (wa !== xa) begin errors++; $display("FAIL %s.A got %0d want %0d", nm, wa, xa); end
    checks++; if (wnn !== xnn) begin errors++; $display("FAIL %s.Nn got %0d want %0d", nm, wnn, xnn); end
    checks++; if (wn !== xn) begin errors++; $display("FAIL %s.N got %0d want %0d", nm, wn, xn); end
  endtask

  task automatic test_reset();
    set_ctx(1'b0, 13'd0, 7'd0, 7'd1);
    set_ctx(1'b1, 13'd0, 7'd0, 7'd1);
    rst_n = 1'b0;
    #3;
    checks++; if ({busy, code_valid, en_out} !== 3'b000) begin errors++; $display("FAIL reset.strobes got %b want 000", {busy, code_valid, en_out}); end
    checks++; if ({k, map, EMErrval} !== '0) begin errors++; $display("FAIL reset.code got %h want 0", {k, map, EMErrval}); end
    checks++; if ({RItype_out, A, Nn, N} !== '0) begin errors++; $display("FAIL reset.ctx got %h want 0", {RItype_out, A, Nn, N}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_calc_k();
    set_ctx(1'b0, 13'd4, 7'd0, 7'd1);
    do_req("k_ri0", 1'b0, 9'sd3, 4'd2, 1'b0, 9'd6, 13'd7, 7'd0, 7'd2, -1, -1);
    set_ctx(1'b1, 13'd4, 7'd0, 7'd1);
    do_req("k_ri1", 1'b1, -9'sd1, 4'd2, 1'b1, 9'd0, 13'd4, 7'd1, 7'd2, -1, -1);
  endtask

  task automatic test_k_zero();
    set_ctx(1'b0, 13'd2, 7'd0, 7'd4);
    do_req("k0_pos", 1'b0, 9'sd5, 4'd0, 1'b1, 9'd9, 13'd7, 7'd0, 7'd5, -1, -1);
    // TEMP = 1 + (2>>1) = 2 meets N<<0 = 2
    set_ctx(1'b1, 13'd1, 7'd1, 7'd2);
    do_req("k0_ri1_neg", 1'b1, -9'sd2, 4'd0, 1'b1, 9'd2, 13'd2, 7'd2, 7'd3, -1, -1);
  endtask

  task automatic test_halving();
    set_ctx(1'b0, 13'd1000, 7'd10, 7'd64);
    do_req("halve", 1'b0, 9'sd0, 4'd4, 1'b0, 9'd0, 13'd500, 7'd5, 7'd33, -1, -1);
  endtask

  task automatic test_ignore_busy();
    set_ctx(1'b0, 13'd4, 7'd0, 7'd1);
    do_req("ignore", 1'b0, 9'sd3, 4'd2, 1'b0, 9'd6, 13'd7, 7'd0, 7'd2, 1, 4);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore.no_accept got busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    set_ctx(1'b0, 13'd4, 7'd0, 7'd1);
    do_req("b2b_first", 1'b0, 9'sd3, 4'd2, 1'b0, 9'd6, 13'd7, 7'd0, 7'd2, -1, -1);
    // Second sample must see A=7, N=2 written back by the first
    do_req("b2b_second", 1'b0, 9'sd3, 4'd2, 1'b0, 9'd6, 13'd10, 7'd0, 7'd3, -1, -1);
    checks++; if (cur_e0 - prev_e0 != 6) begin errors++; $display("FAIL b2b.period got %0d want 6", cur_e0 - prev_e0); end
  endtask

  task automatic test_reset_mid();
    int hits = 0;
    set_ctx(1'b0, 13'd4, 7'd0, 7'd1);
    rit = 1'b0; err = 9'sd3; en_in = 1'b1;
    @(posedge clk); #1;
    en_in = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid.calc got busy=%0b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, code_valid, en_out} !== 3'b000) begin errors++; $display("FAIL rst_mid.strobes got %b want 000", {busy, code_valid, en_out}); end
    checks++; if ({k, map, EMErrval, RItype_out, A, Nn, N} !== '0) begin errors++; $display("FAIL rst_mid.outputs got %h want 0", {k, map, EMErrval, RItype_out, A, Nn, N}); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (en_out !== 1'b0 || code_valid !== 1'b0 || busy !== 1'b0) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL rst_mid.no_writeback got %0d active cycles want 0", hits); end
    do_req("after_rst", 1'b0, 9'sd3, 4'd2, 1'b0, 9'd6, 13'd7, 7'd0, 7'd2, -1, -1);
  endtask

  initial begin
    test_reset();
    test_calc_k();
    test_k_zero();
    test_halving();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
